adaptive_threshold_unit: RTL and testbench
==========================================

Name: adaptive_threshold_unit

Overview:
Parametrised successor of the dual-channel (integrated/filtered) QRS threshold corrector in the Pan-Tompkins chain.
- Sits after the peak detectors and classifies each peak pair as signal or noise on its own; no external npu/spu strobes.
- Performs its own learning phase over the first peaks.
- Tracks the RR-interval average and runs a timed searchback on a missed beat.
- All arithmetic is shift-based fixed point with a parametrised width and parametrised learning rates.

Parameters:
DATA_WIDTH, 16, width of peaks, SPK/NPK and thresholds (signed)
LEARN_PEAKS, 8, number of peak pairs in the learning phase (power of 2, 2..64)
ALPHA_SHIFT, 3, SPK/NPK update rate: x += (pk - x) >>> ALPHA_SHIFT
THR_SHIFT, 2, threshold position: thr1 = npk + ((spk - npk) >>> THR_SHIFT)
SB_SHIFT, 2, searchback SPK update rate
RR_WIDTH, 12, RR counter and average width (unsigned)
RR_INIT, 200, rr_avg value after reset, in samples

Ports:
clk  in  1  clock, rising edge
rstn  in  1  reset, synchronous, active-low
en  in  1  clock enable; when low, all state frozen
sample_tick  in  1  one pulse per ECG sample; advances the RR counter
peak_valid  in  1  peak_i/peak_f valid this cycle
peak_i  in  DATA_WIDTH  integrated-signal peak (signed)
peak_f  in  DATA_WIDTH  filtered-signal peak (signed)
thri_1, thri_2, thrf_1, thrf_2  out  DATA_WIDTH each  thresholds (registered, signed)
qrs  out  1  one-cycle QRS pulse
qrs_sb  out  1  qualifies qrs: beat found by searchback
learn_done  out  1  high once the learning phase has finished
rr_avg  out  RR_WIDTH  running RR average

Behaviour:
- Reset (rstn=0 at a clk edge, including mid-operation): state LEARN, all thresholds/SPK/NPK/accumulators 0, qrs=qrs_sb=learn_done=0, rr_cnt=0, rr_avg=RR_INIT, stored noise peak cleared.
- en=0: nothing updates; qrs and qrs_sb are forced to 0 on that cycle.
- Negative peaks are clamped to 0 at capture.
- Intermediate differences are computed at DATA_WIDTH+1 bits. The >>> operator is arithmetic (floor).
- LEARN state:
  - Each peak_valid accumulates per channel: a max and a sum (DATA_WIDTH+log2(LEARN_PEAKS) bits).
  - qrs stays 0 and thresholds stay 0.
  - On the LEARN_PEAKS-th peak: spk = max>>1, npk = mean>>3 (mean = sum>>log2), thresholds computed per channel, learn_done=1, next state RUN. All of this is visible the next cycle.
- RUN state, on peak_valid (registered, 1-cycle latency):
  - The peak is a signal if peak_i > thri_1 AND peak_f > thrf_1, using pre-update thresholds.
  - Signal: spk per channel updated; qrs=1 next cycle.
  - Noise: npk per channel updated. If peak_i > stored_i, store the pair and sb_pos = rr_cnt.
  - After either update: thr1 = npk + ((spk-npk)>>>THR_SHIFT), thr2 = thr1>>>1. New thresholds are visible the cycle qrs rises.
- RR counter:
  - rr_cnt increments on sample_tick and saturates at all-ones.
  - On a normal QRS: rr_avg += (rr_cnt >> 3) - (rr_avg >> 3). This update is skipped for the first QRS after LEARN.
  - Also on a normal QRS: rr_cnt=0 (a simultaneous tick is discarded), the stored peak is cleared, and sb_done=0.
- Searchback:
  - miss_lim = rr_avg + (rr_avg>>1) + (rr_avg>>3).
  - Evaluated when sample_tick AND rr_cnt >= miss_lim AND sb_done=0 AND no peak_valid in the same cycle. A peak_valid in the same cycle has priority, and the searchback retries on the next tick.
  - If stored_i > thri_2 AND stored_f > thrf_2: spk += (stored - spk)>>>SB_SHIFT per channel, thresholds recomputed, qrs=qrs_sb=1 next cycle.
  - Also on a successful searchback: rr_avg is updated with sb_pos, rr_cnt = rr_cnt - sb_pos, and the stored peak is cleared.
  - Otherwise the searchback does nothing. In both cases sb_done=1, so there is at most one searchback per interval.
- qrs/qrs_sb are exactly one en-cycle wide and never asserted in LEARN.

Test Plan:
- Learn: LEARN_PEAKS=8 pairs of (1000,1000) → learn_done=1 one cycle after the 8th; thri_1=thrf_1=218, thri_2=thrf_2=109, qrs never high.
- Signal: after the learn step, peak (1000,1000) → qrs=1 for exactly 1 cycle, qrs_sb=0; thri_1=234, thri_2=117.
- Noise and floor rounding: then peak (100,100) → qrs=0; npk=121; thri_1=231, thri_2=115.
- Channel disagreement: peak (1000,100) → classified noise, no qrs.
- Searchback:
  - After a QRS (spk=562), send noise (150,150) at tick 50, then no peaks.
  - At rr_cnt=325 (RR_INIT=200): qrs=qrs_sb=1, spk=459, rr_avg=181, rr_cnt=275.
  - Repeat with stored (50,50) < thr2 → no qrs, and no second attempt.
- Control: en=0 for 20 cycles with peaks and ticks → outputs unchanged, qrs=0. rstn=0 mid-RUN → next cycle all outputs 0, rr_avg=200, learn_done=0.

Source files
------------

// File: rtl/adaptive_threshold_unit.sv
// adaptive_threshold_unit
//   Dual-channel (integrated / filtered) QRS threshold tracker for the
//   Pan-Tompkins chain. Classifies each peak pair as signal or noise,
//   learns initial SPK/NPK levels over the first LEARN_PEAKS pairs, tracks
//   the RR-interval average and runs one timed searchback per interval.
//
// Ports
//   clk          rising-edge clock
//   rstn         synchronous active-low reset
//   en           clock enable; when low all state holds, qrs/qrs_sb read 0
//   sample_tick  one pulse per ECG sample, advances the RR counter
//   peak_valid   peak_i / peak_f valid this cycle
//   peak_i       integrated-signal peak (signed, negatives clamped to 0)
//   peak_f       filtered-signal peak (signed, negatives clamped to 0)
//   thri_1/2     integrated-channel thresholds (registered, signed)
//   thrf_1/2     filtered-channel thresholds (registered, signed)
//   qrs          one-cycle QRS pulse
//   qrs_sb       qualifies qrs: beat recovered by searchback
//   learn_done   high once the learning phase has finished
//   rr_avg       running RR average in samples
module adaptive_threshold_unit #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned LEARN_PEAKS = 8,
  parameter int unsigned ALPHA_SHIFT = 3,
  parameter int unsigned THR_SHIFT   = 2,
  parameter int unsigned SB_SHIFT    = 2,
  parameter int unsigned RR_WIDTH    = 12,
  parameter int unsigned RR_INIT     = 200
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         en,
  input  logic                         sample_tick,
  input  logic                         peak_valid,
  input  logic signed [DATA_WIDTH-1:0] peak_i,
  input  logic signed [DATA_WIDTH-1:0] peak_f,
  output logic signed [DATA_WIDTH-1:0] thri_1,
  output logic signed [DATA_WIDTH-1:0] thri_2,
  output logic signed [DATA_WIDTH-1:0] thrf_1,
  output logic signed [DATA_WIDTH-1:0] thrf_2,
  output logic                         qrs,
  output logic                         qrs_sb,
  output logic                         learn_done,
  output logic        [RR_WIDTH-1:0]   rr_avg
);

  localparam int unsigned LG = $clog2(LEARN_PEAKS);
  localparam int unsigned SW = DATA_WIDTH + LG;

  typedef enum logic {LEARN, RUN} state_t;
  state_t state;

  logic signed [DATA_WIDTH-1:0] spk_i, spk_f, npk_i, npk_f;
  logic signed [DATA_WIDTH-1:0] max_i, max_f;
  logic        [SW-1:0]         sum_i, sum_f;
  logic        [LG-1:0]         learn_cnt;
  logic signed [DATA_WIDTH-1:0] stored_i, stored_f;
  logic        [RR_WIDTH-1:0]   rr_cnt, sb_pos;
  logic                         sb_done, rr_primed;
  logic                         qrs_r, qrs_sb_r;

  // x + ((target - x) >>> sh), difference taken one bit wider than the data.
  function automatic logic signed [DATA_WIDTH-1:0] step(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic signed [DATA_WIDTH-1:0] target,
    input int unsigned                  sh
  );
    logic signed [DATA_WIDTH:0] d;
    d = $signed({target[DATA_WIDTH-1], target}) - $signed({x[DATA_WIDTH-1], x});
    return DATA_WIDTH'($signed({x[DATA_WIDTH-1], x}) + (d >>> sh));
  endfunction

  function automatic logic [RR_WIDTH-1:0] rr_upd(
    input logic [RR_WIDTH-1:0] avg,
    input logic [RR_WIDTH-1:0] interval
  );
    return avg - (avg >> 3) + (interval >> 3);
  endfunction

  // Capture-side clamping and learning-phase accumulation.
  logic signed [DATA_WIDTH-1:0] pk_i_c, pk_f_c;
  logic signed [DATA_WIDTH-1:0] max_i_n, max_f_n;
  logic        [SW-1:0]         sum_i_n, sum_f_n;
  logic        [DATA_WIDTH-1:0] mean_i, mean_f;
  logic                         learn_last;

  assign pk_i_c     = peak_i[DATA_WIDTH-1] ? '0 : peak_i;
  assign pk_f_c     = peak_f[DATA_WIDTH-1] ? '0 : peak_f;
  assign max_i_n    = (pk_i_c > max_i) ? pk_i_c : max_i;
  assign max_f_n    = (pk_f_c > max_f) ? pk_f_c : max_f;
  assign sum_i_n    = sum_i + {{LG{1'b0}}, pk_i_c};
  assign sum_f_n    = sum_f + {{LG{1'b0}}, pk_f_c};
  assign mean_i     = sum_i_n[SW-1:LG];
  assign mean_f     = sum_f_n[SW-1:LG];
  assign learn_last = (learn_cnt == LG'(LEARN_PEAKS - 1));

  // Classification and searchback qualification use pre-update thresholds.
  logic                  is_sig, sb_fire, sb_hit;
  logic [RR_WIDTH:0]     miss_lim;

  assign is_sig   = (pk_i_c > thri_1) && (pk_f_c > thrf_1);
  assign miss_lim = {1'b0, rr_avg} + {2'b00, rr_avg[RR_WIDTH-1:1]}
                  + {4'b0000, rr_avg[RR_WIDTH-1:3]};
  assign sb_fire  = (state == RUN) && sample_tick && !peak_valid && !sb_done
                  && ({1'b0, rr_cnt} >= miss_lim);
  assign sb_hit   = (stored_i > thri_2) && (stored_f > thrf_2);

  // Next SPK/NPK for whichever event happens this cycle. Thresholds are a
  // pure function of SPK/NPK (and 0 when both are 0), so they are simply
  // re-registered from the next values every enabled cycle.
  logic signed [DATA_WIDTH-1:0] spk_i_n, spk_f_n, npk_i_n, npk_f_n;
  logic signed [DATA_WIDTH-1:0] thri_1_n, thrf_1_n;

  always_comb begin
    spk_i_n = spk_i;
    spk_f_n = spk_f;
    npk_i_n = npk_i;
    npk_f_n = npk_f;
    if (state == LEARN) begin
      if (peak_valid && learn_last) begin
        spk_i_n = {1'b0, max_i_n[DATA_WIDTH-1:1]};
        spk_f_n = {1'b0, max_f_n[DATA_WIDTH-1:1]};
        npk_i_n = {3'b000, mean_i[DATA_WIDTH-1:3]};
        npk_f_n = {3'b000, mean_f[DATA_WIDTH-1:3]};
      end
    end else if (peak_valid) begin
      if (is_sig) begin
        spk_i_n = step(spk_i, pk_i_c, ALPHA_SHIFT);
        spk_f_n = step(spk_f, pk_f_c, ALPHA_SHIFT);
      end else begin
        npk_i_n = step(npk_i, pk_i_c, ALPHA_SHIFT);
        npk_f_n = step(npk_f, pk_f_c, ALPHA_SHIFT);
      end
    end else if (sb_fire && sb_hit) begin
      spk_i_n = step(spk_i, stored_i, SB_SHIFT);
      spk_f_n = step(spk_f, stored_f, SB_SHIFT);
    end
    thri_1_n = step(npk_i_n, spk_i_n, THR_SHIFT);
    thrf_1_n = step(npk_f_n, spk_f_n, THR_SHIFT);
  end

  assign qrs    = qrs_r & en;
  assign qrs_sb = qrs_sb_r & en;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= LEARN;
      spk_i      <= '0;
      spk_f      <= '0;
      npk_i      <= '0;
      npk_f      <= '0;
      thri_1     <= '0;
      thri_2     <= '0;
      thrf_1     <= '0;
      thrf_2     <= '0;
      max_i      <= '0;
      max_f      <= '0;
      sum_i      <= '0;
      sum_f      <= '0;
      learn_cnt  <= '0;
      stored_i   <= '0;
      stored_f   <= '0;
      sb_pos     <= '0;
      sb_done    <= 1'b0;
      rr_primed  <= 1'b0;
      rr_cnt     <= '0;
      rr_avg     <= RR_WIDTH'(RR_INIT);
      qrs_r      <= 1'b0;
      qrs_sb_r   <= 1'b0;
      learn_done <= 1'b0;
    end else if (en) begin
      qrs_r    <= 1'b0;
      qrs_sb_r <= 1'b0;
      spk_i    <= spk_i_n;
      spk_f    <= spk_f_n;
      npk_i    <= npk_i_n;
      npk_f    <= npk_f_n;
      thri_1   <= thri_1_n;
      thri_2   <= thri_1_n >>> 1;
      thrf_1   <= thrf_1_n;
      thrf_2   <= thrf_1_n >>> 1;

      if (sample_tick && (rr_cnt != '1)) rr_cnt <= rr_cnt + 1'b1;

      case (state)
        LEARN: begin
          if (peak_valid) begin
            max_i     <= max_i_n;
            max_f     <= max_f_n;
            sum_i     <= sum_i_n;
            sum_f     <= sum_f_n;
            learn_cnt <= learn_cnt + 1'b1;
            if (learn_last) begin
              state      <= RUN;
              learn_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (peak_valid) begin
            if (is_sig) begin
              qrs_r     <= 1'b1;
              rr_cnt    <= '0;
              stored_i  <= '0;
              stored_f  <= '0;
              sb_pos    <= '0;
              sb_done   <= 1'b0;
              rr_primed <= 1'b1;
              // The first beat after learning has no valid preceding interval.
              if (rr_primed) rr_avg <= rr_upd(rr_avg, rr_cnt);
            end else if (pk_i_c > stored_i) begin
              stored_i <= pk_i_c;
              stored_f <= pk_f_c;
              sb_pos   <= rr_cnt;
            end
          end else if (sb_fire) begin
            sb_done <= 1'b1;
            if (sb_hit) begin
              qrs_r     <= 1'b1;
              qrs_sb_r  <= 1'b1;
              rr_primed <= 1'b1;
              rr_avg    <= rr_upd(rr_avg, sb_pos);
              // Restart the interval from the recovered beat; this tick is dropped.
              rr_cnt    <= rr_cnt - sb_pos;
              stored_i  <= '0;
              stored_f  <= '0;
              sb_pos    <= '0;
            end
          end
        end
        default: state <= LEARN;
      endcase
    end
  end

endmodule

// File: tb/tb_adaptive_threshold_unit.sv
// Scoreboard bench for adaptive_threshold_unit: expected QRS events (cycle,
// searchback flag, thresholds, rr_avg) are queued by the stimulus and checked
// by an independent monitor; quiescent threshold values are checked inline.
module tb_adaptive_threshold_unit;
  localparam int W  = 16;
  localparam int RW = 12;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic en = 1'b1;
  logic sample_tick = 1'b0;
  logic peak_valid = 1'b0;
  logic signed [W-1:0] peak_i = '0;
  logic signed [W-1:0] peak_f = '0;
  logic signed [W-1:0] thri_1, thri_2, thrf_1, thrf_2;
  logic qrs, qrs_sb, learn_done;
  logic [RW-1:0] rr_avg;

  typedef struct {
    int cyc;
    int sb;
    int ti1, ti2, tf1, tf2;
    int rr;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  adaptive_threshold_unit #(
    .DATA_WIDTH (W),
    .LEARN_PEAKS(8),
    .ALPHA_SHIFT(3),
    .THR_SHIFT  (2),
    .SB_SHIFT   (2),
    .RR_WIDTH   (RW),
    .RR_INIT    (200)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .sample_tick(sample_tick),
    .peak_valid (peak_valid),
    .peak_i     (peak_i),
    .peak_f     (peak_f),
    .thri_1     (thri_1),
    .thri_2     (thri_2),
    .thrf_1     (thrf_1),
    .thrf_2     (thrf_2),
    .qrs        (qrs),
    .qrs_sb     (qrs_sb),
    .learn_done (learn_done),
    .rr_avg     (rr_avg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input int sb, input int t1, input int t2,
                              input int f1, input int f2, input int rr);
    exp_t e;
    e.cyc = 0; e.sb = sb;
    e.ti1 = t1; e.ti2 = t2; e.tf1 = f1; e.tf2 = f2; e.rr = rr;
    return e;
  endfunction

  task automatic chk_thr(input string tag, input int t1, input int t2,
                         input int f1, input int f2);
    chk({tag, ".thri_1"}, int'(thri_1), t1);
    chk({tag, ".thri_2"}, int'(thri_2), t2);
    chk({tag, ".thrf_1"}, int'(thrf_1), f1);
    chk({tag, ".thrf_2"}, int'(thrf_2), f2);
  endtask

  // One stimulus cycle followed by one idle cycle; returns #1 after the
  // capturing edge. A queued event is due at the capturing edge.
  task automatic drive(input logic pv, input int pi, input int pf, input logic tk,
                       input bit want, input exp_t e);
    exp_t x;
    @(posedge clk); #1;
    peak_valid  = pv;
    peak_i      = W'(pi);
    peak_f      = W'(pf);
    sample_tick = tk;
    if (want) begin
      x = e;
      x.cyc = cyc + 1;
      sbq.push_back(x);
    end
    @(posedge clk); #1;
    peak_valid  = 1'b0;
    sample_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  // Monitor: every qrs pulse must match the head of the queue, at its cycle.
  always @(negedge clk) begin
    if (qrs) begin
      if (sbq.size() == 0) begin
        chk("qrs_unexpected", int'(qrs), 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("qrs_cycle", cyc, mon_e.cyc);
        chk("qrs_sb", int'(qrs_sb), mon_e.sb);
        chk("ev.thri_1", int'(thri_1), mon_e.ti1);
        chk("ev.thri_2", int'(thri_2), mon_e.ti2);
        chk("ev.thrf_1", int'(thrf_1), mon_e.tf1);
        chk("ev.thrf_2", int'(thrf_2), mon_e.tf2);
        chk("ev.rr_avg", int'(rr_avg), mon_e.rr);
      end
    end else begin
      if (qrs_sb) chk("qrs_sb_without_qrs", int'(qrs_sb), 0);
      if (sbq.size() != 0 && cyc > sbq[0].cyc) begin
        mon_e = sbq.pop_front();
        chk("qrs_missed", int'(qrs), 1);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t none;
    none = mk(0, 0, 0, 0, 0, 0);

    // Reset state
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_thr("reset", 0, 0, 0, 0);
    chk("reset.learn_done", int'(learn_done), 0);
    chk("reset.rr_avg", int'(rr_avg), 200);
    chk("reset.qrs", int'(qrs), 0);
    rstn = 1'b1;

    // Learning: 8 x (1000,1000) -> spk 500, npk 125, thr1 218, thr2 109
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1000, 1000, 1'b0, 1'b0, none);
      if (k == 6) begin
        chk("learn7.learn_done", int'(learn_done), 0);
        chk_thr("learn7", 0, 0, 0, 0);
      end
    end
    chk("learn.learn_done", int'(learn_done), 1);
    chk_thr("learn", 218, 109, 218, 109);

    // Signal: spk 562, thr1 234; first QRS leaves rr_avg at 200
    drive(1'b1, 1000, 1000, 1'b0, 1'b1, mk(0, 234, 117, 234, 117, 200));
    // Noise with floor rounding: npk 121, thr1 231
    drive(1'b1, 100, 100, 1'b0, 1'b0, none);
    chk_thr("noise", 231, 115, 231, 115);
    // Channel disagreement: noise, npk_i 230, npk_f 118
    drive(1'b1, 1000, 100, 1'b0, 1'b0, none);
    chk_thr("disagree", 313, 156, 229, 114);
    // Negative peaks clamp to 0: npk_i 201, npk_f 103
    drive(1'b1, -400, -400, 1'b0, 1'b0, none);
    chk_thr("clamp", 291, 145, 217, 108);

    // Searchback flow
    do_reset();
    for (int k = 0; k < 8; k++) drive(1'b1, 1000, 1000, 1'b0, 1'b0, none);
    drive(1'b1, 1000, 1000, 1'b0, 1'b1, mk(0, 234, 117, 234, 117, 200));
    repeat (50) drive(1'b0, 0, 0, 1'b1, 1'b0, none);
    drive(1'b1, 150, 150, 1'b0, 1'b0, none);
    chk_thr("sb_noise", 236, 118, 236, 118);
    // Tick 276 is the one seen with rr_cnt = 325 = miss_lim
    for (int i = 0; i < 276; i++)
      drive(1'b0, 0, 0, 1'b1, (i == 275), mk(1, 210, 105, 210, 105, 181));
    // Immediate beat: rr_cnt 275 -> rr_avg 193, spk 526
    drive(1'b1, 1000, 1000, 1'b0, 1'b1, mk(0, 227, 113, 227, 113, 193));
    drive(1'b1, 50, 50, 1'b0, 1'b0, none);
    chk_thr("sb2_noise", 220, 110, 220, 110);
    // Stored peak below thr2: searchback must not produce a beat
    repeat (400) drive(1'b0, 0, 0, 1'b1, 1'b0, none);
    chk_thr("sb2_after", 220, 110, 220, 110);
    chk("sb2_after.rr_avg", int'(rr_avg), 193);

    // Clock enable low: peaks and ticks ignored
    en = 1'b0;
    for (int i = 0; i < 20; i++) drive(1'b1, 1000, 1000, 1'b1, 1'b0, none);
    chk_thr("en_low", 220, 110, 220, 110);
    chk("en_low.rr_avg", int'(rr_avg), 193);
    chk("en_low.learn_done", int'(learn_done), 1);
    en = 1'b1;

    // Reset in RUN
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    chk_thr("midreset", 0, 0, 0, 0);
    chk("midreset.rr_avg", int'(rr_avg), 200);
    chk("midreset.learn_done", int'(learn_done), 0);
    chk("midreset.qrs", int'(qrs), 0);
    chk("midreset.qrs_sb", int'(qrs_sb), 0);
    rstn = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("pending_events", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
